// File: rtl/tt_um_jimktrains_vslc_instr_fetch.sv
// Instruction fetch stage between the SPI EEPROM byte reader and the executor.
//
// Parses the 4-byte program header (start/end address), queues program bytes
// in a small FIFO with a registered head, and hands them to the executor over
// a valid/ready handshake. Each byte is tagged with its EEPROM address and a
// flag marking the first byte of a scan cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   byte_valid/byte_data/byte_addr  byte pulse from the reader
//   hold_n                        low = reader must pause (registered)
//   restart                       1-cycle pulse: reader restarts at start_addr
//   start_addr, end_addr          header fields
//   header_done                   all 4 header bytes captured (sticky)
//   instr_valid/data/addr/first   FIFO head toward the executor
//   instr_ready                   executor consumes the head this cycle
//   overflow                      sticky: a byte was dropped on a full FIFO
module tt_um_jimktrains_vslc_instr_fetch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int PROG_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic [ADDR_W-1:0] byte_addr,
  output logic              hold_n,
  output logic              restart,
  output logic [ADDR_W-1:0] start_addr,
  output logic [PROG_W-1:0] end_addr,
  output logic              header_done,
  output logic              instr_valid,
  output logic [7:0]        instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_first,
  input  logic              instr_ready,
  output logic              overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic              first;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic [PROG_W-1:0] start_q, start_d;
  logic [PROG_W-1:0] end_q, end_d;
  logic              hdr_done_q, hdr_done_d;
  logic              first_pend_q, first_pend_d;
  logic              restart_q, restart_d;
  logic              ovf_q, ovf_d;
  logic              hold_n_q, hold_n_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  entry_t [DEPTH-1:0] mem_q, mem_d;

  logic              is_hdr;
  logic              push_req, push_ok, pop, full, first_bit;
  logic [ADDR_W-1:0] start_ext, end_ext;

  always_comb begin
    start_ext = '0;
    start_ext[PROG_W-1:0] = start_q;
    end_ext = '0;
    end_ext[PROG_W-1:0] = end_q;
  end

  // Addresses 0..3 are the header
  assign is_hdr = (byte_addr[ADDR_W-1:2] == '0);

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign full        = (count_q == CW'(DEPTH));

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    hdr_done_d   = hdr_done_q;
    first_pend_d = first_pend_q;
    restart_d    = 1'b0;
    push_req     = 1'b0;
    first_bit    = 1'b0;

    if (byte_valid && is_hdr) begin
      case (byte_addr[1:0])
        2'd0: start_d[PROG_W-1:8] = byte_data[PROG_W-9:0];
        2'd1: start_d[7:0]        = byte_data;
        2'd2: end_d[PROG_W-1:8]   = byte_data[PROG_W-9:0];
        default: begin
          end_d[7:0] = byte_data;
          hdr_done_d = 1'b1;
        end
      endcase
    end

    case (state_q)
      ST_HDR: begin
        if (byte_valid && is_hdr && byte_addr[1:0] == 2'd3) begin
          state_d      = ST_RUN;
          first_pend_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (byte_valid && !is_hdr) begin
          push_req     = 1'b1;
          first_bit    = first_pend_q;
          first_pend_d = 1'b0;
          // end_addr==0 means an unbounded program
          if (end_q != '0 && byte_addr >= end_ext) begin
            restart_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Skip stale bytes until the reader comes back around to start_addr
        if (byte_valid && !is_hdr && byte_addr == start_ext) begin
          push_req  = 1'b1;
          first_bit = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // A push into a full FIFO is still accepted when the head leaves this cycle
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = '{first: first_bit, addr: byte_addr, data: byte_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q | (push_req && !push_ok);
    // One slot of slack for the byte already in flight from the reader
    hold_n_d = !(count_q >= CW'(DEPTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HDR;
      start_q      <= '0;
      end_q        <= '0;
      hdr_done_q   <= 1'b0;
      first_pend_q <= 1'b0;
      restart_q    <= 1'b0;
      ovf_q        <= 1'b0;
      hold_n_q     <= 1'b1;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      mem_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      end_q        <= end_d;
      hdr_done_q   <= hdr_done_d;
      first_pend_q <= first_pend_d;
      restart_q    <= restart_d;
      ovf_q        <= ovf_d;
      hold_n_q     <= hold_n_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign hold_n      = hold_n_q;
  assign restart     = restart_q;
  assign start_addr  = start_ext;
  assign end_addr    = end_q;
  assign header_done = hdr_done_q;
  assign overflow    = ovf_q;
  assign instr_data  = mem_q[rd_ptr_q].data;
  assign instr_addr  = mem_q[rd_ptr_q].addr;
  assign instr_first = mem_q[rd_ptr_q].first;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_instr_fetch.sv
module tb_tt_um_jimktrains_vslc_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] byte_addr;
  logic        hold_n, restart, header_done;
  logic [15:0] start_addr;
  logic [9:0]  end_addr;
  logic        instr_valid, instr_first, instr_ready, overflow;
  logic [7:0]  instr_data;
  logic [15:0] instr_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tt_um_jimktrains_vslc_instr_fetch #(.DEPTH(4), .ADDR_W(16), .PROG_W(10)) dut (
    .clk(clk), .rst(rst),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_addr(byte_addr),
    .hold_n(hold_n), .restart(restart),
    .start_addr(start_addr), .end_addr(end_addr), .header_done(header_done),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .instr_first(instr_first), .instr_ready(instr_ready), .overflow(overflow)
  );

  typedef struct {
    logic        bv;
    logic [7:0]  bd;
    logic [15:0] ba;
    logic        rdy;
    logic        hold, rs, hdr, ovf, vld, first;
    logic [7:0]  data;
    logic [15:0] addr;
    logic [15:0] sa;
    logic [9:0]  ea;
  } vec_t;

  function automatic vec_t mk(logic bv, logic [7:0] bd, logic [15:0] ba, logic rdy,
                              logic hold, logic rs, logic hdr, logic ovf, logic vld,
                              logic first, logic [7:0] data, logic [15:0] addr,
                              logic [15:0] sa, logic [9:0] ea);
    vec_t v;
    v.bv = bv; v.bd = bd; v.ba = ba; v.rdy = rdy;
    v.hold = hold; v.rs = rs; v.hdr = hdr; v.ovf = ovf; v.vld = vld; v.first = first;
    v.data = data; v.addr = addr; v.sa = sa; v.ea = ea;
    return v;
  endfunction

  // Head fields only matter while the head is valid
  function automatic logic [55:0] pk(logic hold, logic rs, logic hdr, logic ovf, logic vld,
                                     logic first, logic [7:0] data, logic [15:0] addr,
                                     logic [15:0] sa, logic [9:0] ea);
    return {hold, rs, hdr, ovf, vld, vld ? first : 1'b0, vld ? data : 8'h00,
            vld ? addr : 16'h0000, sa, ea};
  endfunction

  task automatic check_vec(input string nm, input vec_t v);
    logic [55:0] exp_v, got_v;
    exp_v = pk(v.hold, v.rs, v.hdr, v.ovf, v.vld, v.first, v.data, v.addr, v.sa, v.ea);
    got_v = pk(hold_n, restart, header_done, overflow, instr_valid, instr_first,
               instr_data, instr_addr, start_addr, end_addr);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (hold,rst,hdr,ovf,vld,first,data,addr,sa,ea)",
               nm, got_v, exp_v);
    end
  endtask

  task automatic drive(input logic bv, input logic [7:0] bd, input logic [15:0] ba,
                       input logic rdy);
    byte_valid = bv; byte_data = bd; byte_addr = ba; instr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    byte_valid = 0; byte_data = 0; byte_addr = 0; instr_ready = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic header(input logic [9:0] s, input logic [9:0] e, input logic rdy);
    drive(1, {6'b0, s[9:8]}, 16'd0, rdy);
    drive(1, s[7:0],         16'd1, rdy);
    drive(1, {6'b0, e[9:8]}, 16'd2, rdy);
    drive(1, e[7:0],         16'd3, rdy);
  endtask

  vec_t tbl [15];
  vec_t v;

  initial begin
    // header parse (rows 0-3), then a bounded program with restart (rows 4-14)
    tbl[0]  = mk(1, 8'h01, 16'd0, 0, 1,0,0,0,0,0, 8'h00, 16'd0, 16'h0100, 10'h000);
    tbl[1]  = mk(1, 8'h20, 16'd1, 0, 1,0,0,0,0,0, 8'h00, 16'd0, 16'h0120, 10'h000);
    tbl[2]  = mk(1, 8'h01, 16'd2, 0, 1,0,0,0,0,0, 8'h00, 16'd0, 16'h0120, 10'h100);
    tbl[3]  = mk(1, 8'h30, 16'd3, 0, 1,0,1,0,0,0, 8'h00, 16'd0, 16'h0120, 10'h130);
    tbl[4]  = mk(1, 8'h00, 16'd0, 1, 1,0,0,0,0,0, 8'h00, 16'd0, 16'h0000, 10'h000);
    tbl[5]  = mk(1, 8'h04, 16'd1, 1, 1,0,0,0,0,0, 8'h00, 16'd0, 16'h0004, 10'h000);
    tbl[6]  = mk(1, 8'h00, 16'd2, 1, 1,0,0,0,0,0, 8'h00, 16'd0, 16'h0004, 10'h000);
    tbl[7]  = mk(1, 8'h06, 16'd3, 1, 1,0,1,0,0,0, 8'h00, 16'd0, 16'h0004, 10'h006);
    tbl[8]  = mk(1, 8'hA1, 16'd4, 1, 1,0,1,0,1,1, 8'hA1, 16'd4, 16'h0004, 10'h006);
    tbl[9]  = mk(1, 8'hA2, 16'd5, 1, 1,0,1,0,1,0, 8'hA2, 16'd5, 16'h0004, 10'h006);
    tbl[10] = mk(1, 8'hA3, 16'd6, 1, 1,1,1,0,1,0, 8'hA3, 16'd6, 16'h0004, 10'h006);
    tbl[11] = mk(1, 8'hB7, 16'd7, 1, 1,0,1,0,0,0, 8'h00, 16'd0, 16'h0004, 10'h006);
    tbl[12] = mk(1, 8'hB8, 16'd8, 1, 1,0,1,0,0,0, 8'h00, 16'd0, 16'h0004, 10'h006);
    tbl[13] = mk(1, 8'hC4, 16'd4, 1, 1,0,1,0,1,1, 8'hC4, 16'd4, 16'h0004, 10'h006);
    tbl[14] = mk(0, 8'h00, 16'd0, 1, 1,0,1,0,0,0, 8'h00, 16'd0, 16'h0004, 10'h006);

    byte_valid = 0; byte_data = 0; byte_addr = 0; instr_ready = 0;
    rst = 1'b1;
    #12;
    check_vec("reset_state", mk(0,0,0,0, 1,0,0,0,0,0, 0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (i == 4) do_reset();
      drive(tbl[i].bv, tbl[i].bd, tbl[i].ba, tbl[i].rdy);
      check_vec($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Fill with executor stalled; hold_n lags count by one cycle
    do_reset();
    header(10'd4, 10'd0, 0);
    drive(1, 8'h10, 16'd4, 0); check_vec("fill1", mk(0,0,0,0, 1,0,1,0,1,1, 8'h10,16'd4, 4,0));
    drive(1, 8'h11, 16'd5, 0); check_vec("fill2", mk(0,0,0,0, 1,0,1,0,1,1, 8'h10,16'd4, 4,0));
    drive(1, 8'h12, 16'd6, 0); check_vec("fill3", mk(0,0,0,0, 1,0,1,0,1,1, 8'h10,16'd4, 4,0));
    drive(1, 8'h13, 16'd7, 0); check_vec("fill4", mk(0,0,0,0, 0,0,1,0,1,1, 8'h10,16'd4, 4,0));
    // full + push + pop: accepted, no overflow
    drive(1, 8'h14, 16'd8, 1); check_vec("full_pp", mk(0,0,0,0, 0,0,1,0,1,0, 8'h11,16'd5, 4,0));
    // full + push, no pop: dropped, overflow sticky, head unchanged
    drive(1, 8'h15, 16'd9, 0); check_vec("ovf_drop", mk(0,0,0,0, 0,0,1,1,1,0, 8'h11,16'd5, 4,0));
    drive(0, 8'h00, 16'd0, 0); check_vec("ovf_hold", mk(0,0,0,0, 0,0,1,1,1,0, 8'h11,16'd5, 4,0));
    drive(0, 8'h00, 16'd0, 1); check_vec("drain1", mk(0,0,0,0, 0,0,1,1,1,0, 8'h12,16'd6, 4,0));
    drive(0, 8'h00, 16'd0, 1); check_vec("drain2", mk(0,0,0,0, 0,0,1,1,1,0, 8'h13,16'd7, 4,0));
    drive(0, 8'h00, 16'd0, 1); check_vec("drain3", mk(0,0,0,0, 1,0,1,1,1,0, 8'h14,16'd8, 4,0));
    drive(0, 8'h00, 16'd0, 1); check_vec("drain4", mk(0,0,0,0, 1,0,1,1,0,0, 8'h00,16'd0, 4,0));

    // end_addr==0: long stream, no restart, only the first byte flagged
    do_reset();
    header(10'd4, 10'd0, 1);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'h5A ^ 8'(i);
      drive(1, d, 16'(4 + i), 1);
      v = mk(0,0,0,0, 1,0,1,0,1, (i == 0), d, 16'(4 + i), 4, 0);
      check_vec($sformatf("stream[%0d]", i), v);
    end
    drive(0, 8'h00, 16'd0, 1); check_vec("stream_end", mk(0,0,0,0, 1,0,1,0,0,0, 0,0, 4,0));

    // async reset with 3 entries queued
    do_reset();
    header(10'd4, 10'd0, 0);
    drive(1, 8'h21, 16'd4, 0);
    drive(1, 8'h22, 16'd5, 0);
    drive(1, 8'h23, 16'd6, 0);
    drive(0, 8'h00, 16'd0, 0); check_vec("pre_rst", mk(0,0,0,0, 0,0,1,0,1,1, 8'h21,16'd4, 4,0));
    #2 rst = 1'b1;
    #1 check_vec("async_rst", mk(0,0,0,0, 1,0,0,0,0,0, 0,0, 0,0));
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 8'h31, 16'd5, 0); check_vec("post_rst_drop", mk(0,0,0,0, 1,0,0,0,0,0, 0,0, 0,0));
    drive(1, 8'h00, 16'd0, 0);
    drive(1, 8'h04, 16'd1, 0);
    drive(1, 8'h00, 16'd2, 0);
    drive(1, 8'h32, 16'd5, 0); check_vec("partial_hdr_drop", mk(0,0,0,0, 1,0,0,0,0,0, 0,0, 4,0));
    drive(1, 8'h00, 16'd3, 0); check_vec("hdr_recapture", mk(0,0,0,0, 1,0,1,0,0,0, 0,0, 4,0));
    drive(1, 8'h33, 16'd5, 0); check_vec("post_hdr_push", mk(0,0,0,0, 1,0,1,0,1,1, 8'h33,16'd5, 4,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_jimktrains_vslc_instr_fetch.md
Name: tt_um_jimktrains_vslc_instr_fetch

Overview:
Sits between the SPI EEPROM byte reader and the executor.
- Parses the 4-byte program header (start/end address).
- Buffers program bytes in a small FIFO and presents them to the executor with a valid/ready handshake, tagging each byte with its EEPROM address and a scan-start flag.
- Generates hold-off back-pressure to the reader and the end-of-program restart request.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 16, EEPROM byte address width
PROG_W, 10, width of header start/end addresses

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
byte_valid  in  1  one-cycle pulse: reader has a byte
byte_data  in  8  byte from reader
byte_addr  in  ADDR_W  EEPROM address of byte_data
hold_n  out  1  low = reader must pause before delivering the next byte
restart  out  1  one-cycle pulse: reader must restart at start_addr
start_addr  out  ADDR_W  zero-extended header start address
end_addr  out  PROG_W  header end address
header_done  out  1  all 4 header bytes captured
instr_valid  out  1  FIFO head valid
instr_data  out  8  FIFO head byte
instr_addr  out  ADDR_W  FIFO head address
instr_first  out  1  head byte is first byte of a scan cycle
instr_ready  in  1  executor consumes head this cycle when instr_valid
overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset values: all outputs 0, except hold_n=1. FIFO empty. State HDR. Header registers 0.
- Header capture applies to a byte_valid byte with byte_addr 0..3:
  - addr 0 -> start_addr[9:8] = byte_data[1:0]
  - addr 1 -> start_addr[7:0]
  - addr 2 -> end_addr[9:8]
  - addr 3 -> end_addr[7:0]
  - Header bytes never enter the FIFO.
  - Capturing addr 3 sets header_done and moves HDR->RUN.
  - header_done stays 1 until reset.
- States: HDR, RUN, WAIT.
  - HDR: only header bytes are accepted; any other byte is discarded.
  - RUN: bytes with byte_addr>3 are pushed.
    - The first push after entering RUN carries first=1; later pushes carry first=0.
    - If end_addr!=0 and byte_addr>={0,end_addr} on a push, assert restart the following cycle (1 cycle) and go to WAIT. That byte is still pushed.
  - WAIT: bytes are discarded until one arrives with byte_addr==start_addr. That byte is pushed with first=1 and the state returns to RUN.
  - end_addr==0: never restart; RUN runs unbounded.
- FIFO:
  - Registered head. instr_valid rises the cycle after a push into an empty FIFO (latency 1).
  - A pop occurs when instr_valid&&instr_ready. The next entry appears the following cycle.
  - Push and pop in the same cycle: both occur; count unchanged. This includes the full case: a push while full with a simultaneous pop is accepted.
  - Push while full without pop: the byte is dropped, overflow is set (sticky), FIFO is unchanged.
  - Pop while empty: no effect.
  - Pointers wrap modulo DEPTH.
  - Count width is log2(DEPTH)+1.
- hold_n = 0 when count>=DEPTH-1 (one slot of slack for the in-flight reader byte), registered; otherwise 1.
- instr_data, instr_addr and instr_first are held stable while instr_valid && !instr_ready.
- Async reset mid-operation: everything returns to reset values immediately. Header must be re-read.

Test Plan:
- Header bytes 0x01,0x20,0x01,0x30 at addr 0..3 -> start_addr=0x0120, end_addr=0x130, header_done=1, FIFO stays empty, instr_valid=0.
- Header (start 0x004, end 0x006), instr_ready=1, bytes 0xA1,0xA2,0xA3 at addr 4,5,6 -> executor receives A1(first=1),A2,A3 in order, each valid 1 cycle after push. restart pulses once after addr 6. Bytes at addr 7,8 are ignored. Re-delivered addr 4 byte arrives with first=1.
- DEPTH=4, instr_ready=0, push bytes -> hold_n falls the cycle after count reaches 3. 5th push dropped, overflow=1, FIFO head unchanged.
- FIFO full with push and instr_ready=1 in the same cycle -> count stays 4, no overflow, order preserved.
- end_addr=0, 20 bytes streamed -> restart never asserts, all bytes delivered in order with only the first flagged first=1.
- rst asserted mid-stream with 3 entries queued -> instr_valid=0, header_done=0, overflow=0, hold_n=1 immediately; subsequent non-header bytes are discarded until addr 3 is re-captured.
